// File: rtl/pdp8_iobus.sv
// PDP-8 IOT bus sequencer: decodes a device code to one slot, steps the enabled
// IOP1/IOP2/IOP4 phases, gathers device status, and registers interrupt requests.
module pdp8_iobus #(
  parameter int                  NDEV         = 4,
  parameter int                  WIDTH        = 12,
  parameter logic [NDEV*6-1:0]   DEV_CODES    = {6'o61, 6'o60, 6'o04, 6'o03},
  parameter int                  PULSE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iot_start,
  input  logic [11:0]             mb,
  input  logic [5:0]              io_select,
  input  logic [WIDTH-1:0]        io_data_in,
  output logic [NDEV-1:0]         dev_sel,
  output logic [2:0]              dev_iop,
  output logic [WIDTH-1:0]        dev_data_out,
  input  logic [NDEV*WIDTH-1:0]   dev_data_in,
  input  logic [NDEV-1:0]         dev_data_avail,
  input  logic [NDEV-1:0]         dev_skip,
  input  logic [NDEV-1:0]         dev_clear_ac,
  input  logic [NDEV-1:0]         dev_irq,
  output logic [WIDTH-1:0]        io_data_out,
  output logic                    io_data_avail,
  output logic                    io_skip,
  output logic                    io_clear_ac,
  output logic                    iot_busy,
  output logic                    iot_done,
  output logic                    io_interrupt,
  output logic [NDEV-1:0]         irq_pending,
  output logic [3:0]              irq_id
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P1   = 3'd1;
  localparam logic [2:0] S_P2   = 3'd2;
  localparam logic [2:0] S_P4   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [3:0] LAST   = 4'(PULSE_CYCLES - 1);

  logic [2:0]       state;
  logic [3:0]       cnt;
  logic [2:0]       iop_en;
  logic [NDEV-1:0]  sel_q;
  logic [NDEV-1:0]  match_oh;
  logic             match_any;
  logic [WIDTH-1:0] sel_data;
  logic [3:0]       irq_id_nxt;
  logic             in_phase;
  logic             unused_mb;

  assign unused_mb = ^mb[11:3];

  // Next enabled phase after the current state; DONE when none remain.
  function automatic logic [2:0] next_phase(input logic [2:0] st, input logic [2:0] en);
    logic [2:0] nxt;
    nxt = S_DONE;
    case (st)
      S_IDLE:  nxt = en[0] ? S_P1 : (en[1] ? S_P2 : (en[2] ? S_P4 : S_DONE));
      S_P1:    nxt = en[1] ? S_P2 : (en[2] ? S_P4 : S_DONE);
      S_P2:    nxt = en[2] ? S_P4 : S_DONE;
      default: nxt = S_DONE;
    endcase
    return nxt;
  endfunction

  // Scan downward so the lowest matching slot wins on duplicate codes.
  always_comb begin
    match_oh   = '0;
    match_any  = 1'b0;
    irq_id_nxt = 4'd0;
    sel_data   = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (DEV_CODES[6*i +: 6] == io_select) begin
        match_oh    = '0;
        match_oh[i] = 1'b1;
        match_any   = 1'b1;
      end
      if (dev_irq[i]) irq_id_nxt = 4'(i);
    end
    for (int i = 0; i < NDEV; i++) begin
      if (sel_q[i]) sel_data = sel_data | dev_data_in[i*WIDTH +: WIDTH];
    end
  end

  assign in_phase = (state == S_P1) || (state == S_P2) || (state == S_P4);
  assign dev_sel  = in_phase ? sel_q : '0;
  assign dev_iop  = {state == S_P4, state == S_P2, state == S_P1};
  assign iot_busy = (state != S_IDLE);
  assign iot_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      iop_en        <= 3'd0;
      sel_q         <= '0;
      dev_data_out  <= '0;
      io_data_out   <= '0;
      io_data_avail <= 1'b0;
      io_skip       <= 1'b0;
      io_clear_ac   <= 1'b0;
      io_interrupt  <= 1'b0;
      irq_pending   <= '0;
      irq_id        <= 4'd0;
    end else begin
      irq_pending  <= dev_irq;
      io_interrupt <= |dev_irq;
      irq_id       <= irq_id_nxt;
      case (state)
        S_IDLE: begin
          if (iot_start) begin
            iop_en        <= mb[2:0];
            dev_data_out  <= io_data_in;
            sel_q         <= match_oh;
            cnt           <= 4'd0;
            io_data_out   <= '0;
            io_data_avail <= 1'b0;
            io_skip       <= 1'b0;
            io_clear_ac   <= 1'b0;
            state         <= match_any ? next_phase(S_IDLE, mb[2:0]) : S_DONE;
          end
        end
        S_P1, S_P2, S_P4: begin
          if (cnt == LAST) begin
            cnt   <= 4'd0;
            state <= next_phase(state, iop_en);
            if (|(dev_skip & sel_q))     io_skip     <= 1'b1;
            if (|(dev_clear_ac & sel_q)) io_clear_ac <= 1'b1;
            if (|(dev_data_avail & sel_q)) begin
              io_data_out   <= sel_data;
              io_data_avail <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdp8_iobus.sv
// Directed bench for pdp8_iobus: one instance at PULSE_CYCLES=1, one at 3 with
// a duplicated device code.
module tb_pdp8_iobus;
  logic        clk = 1'b0;
  logic        reset, iot_start, start3;
  logic [11:0] mb, io_data_in;
  logic [5:0]  io_select;
  logic [47:0] dev_data_in;
  logic [3:0]  dev_data_avail, dev_skip, dev_clear_ac, dev_irq;

  logic [3:0]  dev_sel, irq_pending, irq_id;
  logic [2:0]  dev_iop;
  logic [11:0] dev_data_out, io_data_out;
  logic        io_data_avail, io_skip, io_clear_ac, iot_busy, iot_done, io_interrupt;

  logic [3:0]  dev_sel3, irq_pending3, irq_id3;
  logic [2:0]  dev_iop3;
  logic [11:0] dev_data_out3, io_data_out3;
  logic        io_data_avail3, io_skip3, io_clear_ac3, iot_busy3, iot_done3, io_interrupt3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pdp8_iobus u_dut (
    .clk(clk), .reset(reset), .iot_start(iot_start), .mb(mb), .io_select(io_select),
    .io_data_in(io_data_in), .dev_sel(dev_sel), .dev_iop(dev_iop), .dev_data_out(dev_data_out),
    .dev_data_in(dev_data_in), .dev_data_avail(dev_data_avail), .dev_skip(dev_skip),
    .dev_clear_ac(dev_clear_ac), .dev_irq(dev_irq), .io_data_out(io_data_out),
    .io_data_avail(io_data_avail), .io_skip(io_skip), .io_clear_ac(io_clear_ac),
    .iot_busy(iot_busy), .iot_done(iot_done), .io_interrupt(io_interrupt),
    .irq_pending(irq_pending), .irq_id(irq_id)
  );

  pdp8_iobus #(.DEV_CODES({6'o60, 6'o60, 6'o04, 6'o03}), .PULSE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .iot_start(start3), .mb(mb), .io_select(io_select),
    .io_data_in(io_data_in), .dev_sel(dev_sel3), .dev_iop(dev_iop3), .dev_data_out(dev_data_out3),
    .dev_data_in(dev_data_in), .dev_data_avail(dev_data_avail), .dev_skip(dev_skip),
    .dev_clear_ac(dev_clear_ac), .dev_irq(dev_irq), .io_data_out(io_data_out3),
    .io_data_avail(io_data_avail3), .io_skip(io_skip3), .io_clear_ac(io_clear_ac3),
    .iot_busy(iot_busy3), .iot_done(iot_done3), .io_interrupt(io_interrupt3),
    .irq_pending(irq_pending3), .irq_id(irq_id3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    iot_start = 0; start3 = 0; mb = '0; io_select = '0; io_data_in = '0;
    dev_data_in = '0; dev_data_avail = '0; dev_skip = '0; dev_clear_ac = '0; dev_irq = '0;
  endtask

  task automatic test_reset();
    clear_stim();
    reset = 0; iot_start = 1; start3 = 1; mb = 12'o7007; io_select = 6'o03; dev_irq = 4'b1111;
    tick(); tick();
    checks++;
    if ({dev_sel, dev_iop, iot_busy, iot_done} !== 9'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {dev_sel, dev_iop, iot_busy, iot_done});
    end
    checks++;
    if ({io_interrupt, irq_pending, irq_id} !== 9'd0) begin
      errors++; $display("FAIL reset_irq: got %b want 0", {io_interrupt, irq_pending, irq_id});
    end
    checks++;
    if ({dev_data_out, io_data_out, io_data_avail, io_skip, io_clear_ac, iot_busy3} !== 28'd0) begin
      errors++; $display("FAIL reset_data: got %h want 0",
        {dev_data_out, io_data_out, io_data_avail, io_skip, io_clear_ac, iot_busy3});
    end
    clear_stim();
    reset = 1;
    tick();
    checks++;
    if (iot_busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", iot_busy); end
  endtask

  task automatic test_full_sequence();
    io_select = 6'o04; mb = 12'o6037; io_data_in = 12'o1234; iot_start = 1;
    dev_data_avail = 4'b0010; dev_data_in[12 +: 12] = 12'o7070;
    tick();
    iot_start = 0; io_data_in = 12'o0000;
    checks++;
    if ({dev_sel, dev_iop, iot_busy, iot_done} !== {4'b0010, 3'b001, 1'b1, 1'b0}) begin
      errors++; $display("FAIL full_p1: got %b want 001000110", {dev_sel, dev_iop, iot_busy, iot_done});
    end
    checks++;
    if (dev_data_out !== 12'o1234) begin errors++; $display("FAIL data_latch: got %o want 1234", dev_data_out); end
    dev_clear_ac = 4'b0010;
    tick();
    dev_clear_ac = 4'b0000;
    checks++;
    if ({dev_sel, dev_iop} !== {4'b0010, 3'b010}) begin
      errors++; $display("FAIL full_p2: got %b want 0010010", {dev_sel, dev_iop});
    end
    tick();
    checks++;
    if ({dev_sel, dev_iop} !== {4'b0010, 3'b100}) begin
      errors++; $display("FAIL full_p4: got %b want 0010100", {dev_sel, dev_iop});
    end
    tick();
    checks++;
    if ({dev_sel, dev_iop, iot_busy, iot_done} !== {4'b0000, 3'b000, 1'b1, 1'b1}) begin
      errors++; $display("FAIL full_done: got %b want 000000011", {dev_sel, dev_iop, iot_busy, iot_done});
    end
    checks++;
    if ({io_data_out, io_data_avail, io_clear_ac, io_skip} !== {12'o7070, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL full_result: got %h want %h",
        {io_data_out, io_data_avail, io_clear_ac, io_skip}, {12'o7070, 3'b110});
    end
    tick();
    checks++;
    if ({iot_busy, iot_done, io_data_out} !== {2'b00, 12'o7070}) begin
      errors++; $display("FAIL full_idle_hold: got %h want %h", {iot_busy, iot_done, io_data_out}, {2'b00, 12'o7070});
    end
    clear_stim();
  endtask

  task automatic test_skip_phase();
    io_select = 6'o03; mb = 12'o7005; iot_start = 1;
    tick();
    iot_start = 0; dev_skip = 4'b0001;
    checks++;
    if ({dev_sel, dev_iop} !== {4'b0001, 3'b001}) begin
      errors++; $display("FAIL skip_p1: got %b want 0001001", {dev_sel, dev_iop});
    end
    tick();
    dev_skip = 4'b0000; dev_data_avail = 4'b0001; dev_data_in[0 +: 12] = 12'o0101;
    checks++;
    if ({dev_sel, dev_iop} !== {4'b0001, 3'b100}) begin
      errors++; $display("FAIL skip_p2_bypass: got %b want 0001100", {dev_sel, dev_iop});
    end
    tick();
    clear_stim();
    checks++;
    if ({iot_done, io_skip, io_data_avail, io_data_out} !== {3'b111, 12'o0101}) begin
      errors++; $display("FAIL skip_done: got %h want %h", {iot_done, io_skip, io_data_avail, io_data_out}, {3'b111, 12'o0101});
    end
    tick();
  endtask

  task automatic test_no_match();
    io_select = 6'o77; mb = 12'o0007; iot_start = 1;
    tick();
    iot_start = 0;
    checks++;
    if ({iot_done, dev_sel, dev_iop} !== {1'b1, 4'b0000, 3'b000}) begin
      errors++; $display("FAIL nomatch_done: got %b want 10000000", {iot_done, dev_sel, dev_iop});
    end
    checks++;
    if ({io_data_out, io_data_avail, io_skip, io_clear_ac} !== 15'd0) begin
      errors++; $display("FAIL nomatch_results: got %h want 0", {io_data_out, io_data_avail, io_skip, io_clear_ac});
    end
    tick();
    clear_stim();
  endtask

  task automatic test_pulse3_dup();
    logic [2:0] exp_iop;
    logic [3:0] exp_sel;
    io_select = 6'o60; mb = 12'o0007; start3 = 1;
    tick();
    start3 = 0;
    for (int c = 1; c <= 10; c++) begin
      exp_iop = (c <= 3) ? 3'b001 : (c <= 6) ? 3'b010 : (c <= 9) ? 3'b100 : 3'b000;
      exp_sel = (c <= 9) ? 4'b0100 : 4'b0000;
      checks++;
      if ({dev_sel3, dev_iop3, iot_done3} !== {exp_sel, exp_iop, c == 10}) begin
        errors++; $display("FAIL pulse3_cycle%0d: got %b want %b", c, {dev_sel3, dev_iop3, iot_done3},
          {exp_sel, exp_iop, c == 10});
      end
      tick();
    end
    checks++;
    if (iot_busy3 !== 1'b0) begin errors++; $display("FAIL pulse3_idle: got %b want 0", iot_busy3); end
    clear_stim();
  endtask

  task automatic test_irq();
    dev_irq = 4'b1010;
    tick();
    checks++;
    if ({io_interrupt, irq_pending, irq_id} !== {1'b1, 4'b1010, 4'd1}) begin
      errors++; $display("FAIL irq_1010: got %b want 110100001", {io_interrupt, irq_pending, irq_id});
    end
    dev_irq = 4'b1000;
    tick();
    checks++;
    if ({io_interrupt, irq_pending, irq_id} !== {1'b1, 4'b1000, 4'd3}) begin
      errors++; $display("FAIL irq_1000: got %b want 110000011", {io_interrupt, irq_pending, irq_id});
    end
    dev_irq = 4'b0000;
    tick();
    checks++;
    if ({io_interrupt, irq_pending, irq_id} !== 9'd0) begin
      errors++; $display("FAIL irq_clear: got %b want 0", {io_interrupt, irq_pending, irq_id});
    end
  endtask

  task automatic test_busy_reset();
    io_select = 6'o03; mb = 12'o0007; iot_start = 1; io_data_in = 12'o4444;
    tick();
    iot_start = 0; dev_skip = 4'b0001;
    tick();
    dev_skip = 4'b0000;
    io_select = 6'o04; io_data_in = 12'o1111; iot_start = 1;
    tick();
    iot_start = 0;
    checks++;
    if ({dev_sel, dev_iop, dev_data_out, io_skip} !== {4'b0001, 3'b100, 12'o4444, 1'b1}) begin
      errors++; $display("FAIL busy_ignore: got %h want %h", {dev_sel, dev_iop, dev_data_out, io_skip},
        {4'b0001, 3'b100, 12'o4444, 1'b1});
    end
    reset = 0;
    tick();
    checks++;
    if ({iot_done, iot_busy, dev_sel, dev_iop, dev_data_out, io_skip} !== 22'd0) begin
      errors++; $display("FAIL abort_reset: got %h want 0", {iot_done, iot_busy, dev_sel, dev_iop, dev_data_out, io_skip});
    end
    reset = 1;
    tick();
    checks++;
    if ({iot_done, iot_busy} !== 2'b00) begin
      errors++; $display("FAIL abort_no_done: got %b want 00", {iot_done, iot_busy});
    end
    clear_stim();
  endtask

  initial begin
    reset = 0;
    clear_stim();
    test_reset();
    test_full_sequence();
    test_skip_phase();
    test_no_match();
    test_pulse3_dup();
    test_irq();
    test_busy_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pdp8_iobus.md
PDP8_IOBUS -- requirements
Module: pdp8_iobus

Interface
REQ-001 Parameter NDEV, default 4: number of device slots, 1..16.
REQ-002 Parameter WIDTH, default 12: data width.
REQ-003 Parameter DEV_CODES, default {6'o61,6'o60,6'o04,6'o03}: packed NDEV*6 device codes; slot i code = bits [6i+5:6i].
REQ-004 Parameter PULSE_CYCLES, default 1: duration of each IOP phase in clocks, 1..15.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 iot_start  in  1  one-cycle request to run an IOT.
REQ-008 mb  in  12  instruction; mb[2:0] = IOP4/IOP2/IOP1 enables.
REQ-009 io_select  in  6  device code of the IOT.
REQ-010 io_data_in  in  WIDTH  AC value, broadcast to devices.
REQ-011 dev_sel  out  NDEV  one-hot selected slot during phases.
REQ-012 dev_iop  out  3  one-hot active phase {IOP4,IOP2,IOP1}.
REQ-013 dev_data_out  out  WIDTH  copy of io_data_in latched at iot_start.
REQ-014 dev_data_in  in  NDEV*WIDTH  per-slot read data.
REQ-015 dev_data_avail, dev_skip, dev_clear_ac, dev_irq  in  NDEV each  per-slot status.
REQ-016 io_data_out  out  WIDTH; io_data_avail, io_skip, io_clear_ac  out  1: IOT result.
REQ-017 iot_busy  out  1; iot_done  out  1: sequencer status.
REQ-018 io_interrupt  out  1; irq_pending  out  NDEV; irq_id  out  4: interrupt aggregation.

Function
REQ-019 FSM states IDLE, P1, P2, P4, DONE; iot_busy=1 in all but IDLE.
REQ-020 IDLE + iot_start: latch io_select, mb[2:0], io_data_in; clear result registers; match slot = lowest index i with DEV_CODES slot i == io_select.
REQ-021 No match: go to DONE directly; results remain 0; dev_sel stays 0.
REQ-022 Match: visit P1, P2, P4 in order, entering only phases whose mb bit is set; mb[2:0]=0 goes straight to DONE.
REQ-023 Each entered phase lasts exactly PULSE_CYCLES clocks; dev_iop bit and dev_sel held for the whole phase; both 0 outside phases.
REQ-024 Last cycle of each phase: io_skip |= dev_skip[slot]; io_clear_ac |= dev_clear_ac[slot]; if dev_data_avail[slot], io_data_out <= slot data and io_data_avail <= 1 (later phase overwrites).
REQ-025 DONE lasts one cycle with iot_done=1, then IDLE; result outputs hold until next accepted iot_start.
REQ-026 Latency, PULSE_CYCLES=1, mb[2:0]=7: start accepted cycle 0, P1 cycle 1, P2 cycle 2, P4 cycle 3, iot_done cycle 4.
REQ-027 iot_start while iot_busy=1 is ignored; no queuing.
REQ-028 irq_pending <= dev_irq every cycle (one-clock registered); io_interrupt <= |dev_irq.
REQ-029 irq_id <= index of lowest set dev_irq bit, 0 when none; unused upper bits 0.
REQ-030 Duplicate codes in DEV_CODES: lowest index wins, higher slots never selected.

Reset
REQ-031 reset=0 at a clock edge: state IDLE; dev_sel, dev_iop, dev_data_out, io_data_out, io_data_avail, io_skip, io_clear_ac, iot_busy, iot_done, io_interrupt, irq_pending, irq_id all 0.
REQ-032 Reset mid-IOT aborts: no iot_done; outputs per REQ-031 on the following cycle; iot_start concurrent with reset ignored.

Verification
REQ-033 io_select=6'o03, mb[2:0]=3'b101, slot 0 dev_skip=1 in P1, dev_data_avail=1 with data 12'o0101 in P4 -> P2 skipped, iot_done at cycle 3, io_skip=1, io_data_out=12'o0101.
REQ-034 io_select=6'o77 (no match), mb[2:0]=7 -> iot_done at cycle 1, dev_sel never set, all results 0.
REQ-035 PULSE_CYCLES=3, io_select=6'o60, mb[2:0]=7 -> dev_sel=4'b0100, each dev_iop bit high 3 cycles, iot_done at cycle 10.
REQ-036 dev_irq=4'b1010 -> next cycle io_interrupt=1, irq_pending=4'b1010, irq_id=1; dev_irq=0 -> next cycle all 0.
REQ-037 iot_start repeated during P2, then reset=0 during P4 -> second start ignored, no iot_done, all outputs 0 the cycle after reset.
